// File: rtl/sum_pkg.sv
// Shared types and default sizing for the frame-sum accumulator.
package sum_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int DEFAULT_N = 8;
  localparam int DEFAULT_K = 4;

endpackage

// File: rtl/sum_nbit_1cc.sv
// Combinational unsigned adder: one N-bit garbler operand plus one N-bit
// evaluator operand, full N+1-bit result.
module sum_nbit_1cc #(
  parameter int N = 8
) (
  input  logic [N-1:0] g_input,
  input  logic [N-1:0] e_input,
  output logic [N:0]   o
);

  assign o = {1'b0, g_input} + {1'b0, e_input};

endmodule

// File: rtl/sum_acc_nbit.sv
// Accumulates K per-beat sums (g_input + e_input) into one frame sum and
// hands it to a valid/ready consumer; the frame result is held until taken.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready in the same cycle, and a source
// holding valid keeps its payload stable until the transfer.
module sum_acc_nbit
  import sum_pkg::*;
#(
  parameter  int N = DEFAULT_N,
  parameter  int K = DEFAULT_K,
  localparam int W = N + 1 + $clog2(K)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] g_input,
  input  logic [N-1:0] e_input,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] o,
  output state_t       dbg_state
);

  localparam int CNT_W = $clog2(K + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K);

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     o_q, o_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N:0]       beat_sum;
  logic             accept;

  sum_nbit_1cc #(.N(N)) u_beat_add (
    .g_input (g_input),
    .e_input (e_input),
    .o       (beat_sum)
  );

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign accept    = in_valid && in_ready;
  assign o         = o_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d = W'(beat_sum);
          cnt_d = CNT_ONE;
          if (cnt_d == CNT_LAST) begin
            state_d = S_HOLD;
            o_d     = acc_d;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (accept) begin
          acc_d = acc_q + W'(beat_sum);
          cnt_d = cnt_q + CNT_ONE;
          // o captures the sum including the closing beat.
          if (cnt_d == CNT_LAST) begin
            state_d = S_HOLD;
            o_d     = acc_d;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
    end
  end

endmodule

// File: tb/tb_sum_acc_nbit.sv
// Self-checking bench for sum_acc_nbit: a K=4 instance and a K=1 instance,
// checked against a plain-arithmetic frame-sum model.
module tb_sum_acc_nbit;
  import sum_pkg::*;

  localparam int N  = 8;
  localparam int K  = 4;
  localparam int W  = N + 1 + $clog2(K);
  localparam int W1 = N + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [N-1:0]  g_in = '0, e_in = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  o;
  state_t        dbg_state;

  logic          in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [N-1:0]  g_in1 = '0, e_in1 = '0;
  logic          in_ready1, out_valid1;
  logic [W1-1:0] o1;
  state_t        dbg_state1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  sum_acc_nbit #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .g_input(g_in), .e_input(e_in), .out_valid(out_valid),
    .out_ready(out_ready), .o(o), .dbg_state(dbg_state)
  );

  sum_acc_nbit #(.N(N), .K(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .g_input(g_in1), .e_input(e_in1), .out_valid(out_valid1),
    .out_ready(out_ready1), .o(o1), .dbg_state(dbg_state1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat from a negedge; returns at the negedge after acceptance.
  task automatic send_beat(input logic [N-1:0] g, input logic [N-1:0] e);
    int waited = 0;
    in_valid = 1'b1; g_in = g; e_in = e;
    while (!in_ready && waited < 50) begin
      @(negedge clk); waited++;
    end
    if (waited >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame sum from the arithmetic definition: sum of g+e over all beats.
  function automatic logic [W-1:0] frame_sum(input logic [N-1:0] g[K], input logic [N-1:0] e[K]);
    int unsigned s = 0;
    for (int i = 0; i < K; i++) s += int'(g[i]) + int'(e[i]);
    return W'(s);
  endfunction

  task automatic send_frame(input logic [N-1:0] g[K], input logic [N-1:0] e[K], input int max_gap);
    exp_q.push_back(frame_sum(g, e));
    for (int i = 0; i < K; i++) begin
      send_beat(g[i], e[i]);
      if (i < K - 1) begin
        check("no_valid_mid_frame", 32'(out_valid), 32'd0);
        if (max_gap > 0) idle($urandom_range(max_gap, 0));
      end
    end
  endtask

  // Called right after the closing beat: latency-1 result then handoff.
  task automatic check_result_and_take(input string tag);
    logic [W-1:0] exp;
    exp = exp_q.pop_front();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_o"}, 32'(o), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_o_kept"}, 32'(o), 32'(exp));
  endtask

  initial begin
    logic [N-1:0] g[K];
    logic [N-1:0] e[K];
    logic [W-1:0] held;

    // Reset
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_o", 32'(o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    idle(2);
    rst = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    idle(1);

    // Directed back-to-back frame
    g = '{8'hA9, 8'h74, 8'hFF, 8'h00};
    e = '{8'h7B, 8'h9D, 8'hFF, 8'h01};
    send_frame(g, e, 0);
    check("b2b_const_o", 32'(o), 32'h434);
    check_result_and_take("b2b");

    // Maximum operands
    g = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    e = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame(g, e, 0);
    check("max_const_o", 32'(o), 32'h7F8);
    check_result_and_take("max");

    // Same beats as the back-to-back frame with idle bubbles
    g = '{8'hA9, 8'h74, 8'hFF, 8'h00};
    e = '{8'h7B, 8'h9D, 8'hFF, 8'h01};
    send_frame(g, e, 4);
    check("bubble_const_o", 32'(o), 32'h434);
    check_result_and_take("bubble");

    // Backpressure with in_valid held high while the result is held
    for (int i = 0; i < K; i++) begin
      g[i] = N'($urandom); e[i] = N'($urandom);
    end
    send_frame(g, e, 0);
    held = exp_q.pop_front();
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      g_in = N'($urandom); e_in = N'($urandom);
      @(posedge clk); @(negedge clk);
      check("bp_o_stable", 32'(o), 32'(held));
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    // Release with a beat still offered: it must not be taken this cycle.
    g_in = 8'h55; e_in = 8'h55;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_idle_state", 32'(dbg_state), 32'(S_IDLE));
    for (int i = 0; i < K; i++) begin
      g[i] = N'($urandom); e[i] = N'($urandom);
    end
    send_frame(g, e, 0);
    check_result_and_take("after_bp");

    // Reset mid-frame discards the partial sum
    send_beat(8'h80, 8'h80);
    send_beat(8'h40, 8'h40);
    rst = 1'b0;
    #1;
    check("midrst_o", 32'(o), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    g = '{8'h01, 8'h01, 8'h01, 8'h01};
    e = '{8'h01, 8'h01, 8'h01, 8'h01};
    send_frame(g, e, 0);
    check("midrst_const_o", 32'(o), 32'h008);
    check_result_and_take("midrst");

    // Random frames; out_ready kept high during accumulation (ignored there)
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < K; i++) begin
        g[i] = N'($urandom); e[i] = N'($urandom);
      end
      out_ready = 1'($urandom_range(1, 0));
      send_frame(g, e, 2);
      out_ready = 1'b0;
      if (out_ready == 1'b0) begin
        held = exp_q[0];
        idle($urandom_range(3, 0));
        check("rnd_hold_o", 32'(o), 32'(held));
      end
      check_result_and_take("rnd");
    end

    // K=1 instance
    check("k1_idle_valid", 32'(out_valid1), 32'd0);
    in_valid1 = 1'b1; g_in1 = 8'hFF; e_in1 = 8'hFF;
    @(posedge clk); @(negedge clk);
    in_valid1 = 1'b0;
    check("k1_valid", 32'(out_valid1), 32'd1);
    check("k1_o", 32'(o1), 32'h1FE);
    check("k1_in_ready", 32'(in_ready1), 32'd0);
    out_ready1 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready1 = 1'b0;
    check("k1_valid_drop", 32'(out_valid1), 32'd0);
    for (int b = 0; b < 6; b++) begin
      logic [N-1:0] ga, ea;
      ga = N'($urandom); ea = N'($urandom);
      in_valid1 = 1'b1; g_in1 = ga; e_in1 = ea;
      @(posedge clk); @(negedge clk);
      in_valid1 = 1'b0;
      check("k1_rnd_valid", 32'(out_valid1), 32'd1);
      check("k1_rnd_o", 32'(o1), 32'(int'(ga) + int'(ea)));
      out_ready1 = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready1 = 1'b0;
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sum_acc_nbit.md
SUM_ACC_NBIT -- requirements
Module: sum_acc_nbit

Interface
REQ-001 Parameter N, default 8: width of each operand.
REQ-002 Parameter K, default 4: operand pairs summed per frame; K>=1.
REQ-003 Derived constant W = N+1+$clog2(K): output width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  g_input/e_input carry a beat.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 g_input  input  N  garbler operand.
REQ-009 e_input  input  N  evaluator operand.
REQ-010 out_valid  output  1  o holds a completed frame sum.
REQ-011 out_ready  input  1  consumer takes o this cycle.
REQ-012 o  output  W  frame sum.

Function
REQ-013 Beat accepted iff in_valid && in_ready on a rising edge; per-beat sum = g_input + e_input, N+1 bits, unsigned.
REQ-014 FSM states S_IDLE, S_ACC, S_HOLD.
REQ-015 S_IDLE: in_ready=1, out_valid=0; on accept, acc <= beat sum (zero-extended to W), cnt <= 1, next S_ACC; if K==1, next S_HOLD.
REQ-016 S_ACC: in_ready=1; on accept, acc <= acc + beat sum, cnt <= cnt+1; on the K-th accepted beat, next S_HOLD.
REQ-017 Cycles without in_valid in S_IDLE/S_ACC leave acc, cnt and state unchanged.
REQ-018 Entry to S_HOLD: o <= final sum, including the K-th beat; out_valid=1 on the cycle after the K-th accept (latency 1).
REQ-019 S_HOLD: in_ready=0, out_valid=1, o stable; in_valid ignored.
REQ-020 S_HOLD with out_ready=1: next S_IDLE; out_valid=0 and in_ready=1 from the next cycle; no same-cycle accept of a new beat.
REQ-021 out_ready ignored outside S_HOLD.
REQ-022 No overflow: W holds K*(2^(N+1)-2); arithmetic is unsigned and never wraps.
REQ-023 o keeps the last frame value after handoff until the next S_HOLD entry.

Reset
REQ-024 rst low asynchronously forces: state S_IDLE, acc=0, cnt=0, o=0, out_valid=0.
REQ-025 in_ready reads 1 during and immediately after reset release.
REQ-026 Reset mid-frame discards the partial sum; the next frame starts from zero.

Structure
REQ-027 Shared package sum_pkg holds: state_t enum {S_IDLE, S_ACC, S_HOLD} and the default N and K constants.
REQ-028 The per-beat adder is an instance of sum_nbit_1cc #(.N(N)), ports g_input, e_input, o.
REQ-029 Counter width is $clog2(K+1).
REQ-030 No other sub-modules.

Verification (N=8, K=4 unless stated)
REQ-031 Beats (A9,7B),(74,9D),(FF,FF),(00,01), back-to-back -> one cycle later out_valid=1, o=0x434.
REQ-032 Four beats of (FF,FF) -> o=0x7F8, no overflow.
REQ-033 Frame with idle bubbles between beats -> same o as the back-to-back frame.
REQ-034 Backpressure: out_ready=0 for 10 cycles with in_valid=1 -> o and out_valid stable, in_ready=0, no beats absorbed; out_ready=1 -> out_valid drops the next cycle.
REQ-035 Two beats, then rst low, then four beats of (01,01) -> o=0x008.
REQ-036 K=1 instance (W=9): beat (FF,FF) -> out_valid next cycle, o=0x1FE.
